tone_transmitter: RTL

TONE_TRANSMITTER -- requirements
Module: tone_transmitter

---
 rtl/tone_pkg.sv | 47 ++++
 rtl/ms_tick_gen.sv | 29 ++
 rtl/tone_transmitter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/tone_pkg.sv
// Shared types and band tables for the tone transmitter.
// Band codes 1..5 follow the receiver numbering bp1..bp5.
package tone_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } toneState_e;

    localparam int unsigned BAND_HZ [5] = '{1000, 1500, 2000, 2500, 3000};

    function automatic logic isValidCode(input logic [2:0] code);
        return (code >= 3'd1) && (code <= 3'd5);
    endfunction

    // Cycles per half period of band `code`; 0 for codes outside 1..5.
    function automatic int unsigned halfPeriod(input int unsigned clkHz,
                                               input logic [2:0] code);
        int unsigned f;
        f = 0;
        case (code)
            3'd1:    f = BAND_HZ[0];
            3'd2:    f = BAND_HZ[1];
            3'd3:    f = BAND_HZ[2];
            3'd4:    f = BAND_HZ[3];
            3'd5:    f = BAND_HZ[4];
            default: f = 0;
        endcase
        return (f == 0) ? 0 : clkHz / (2 * f);
    endfunction

    function automatic logic [4:0] bandOneHot(input logic [2:0] code);
        logic [4:0] oh;
        oh = '0;
        case (code)
            3'd1:    oh = 5'b00001;
            3'd2:    oh = 5'b00010;
            3'd3:    oh = 5'b00100;
            3'd4:    oh = 5'b01000;
            3'd5:    oh = 5'b10000;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every DIV clocks.
// Sync clear holds the count at 0 so timing restarts cleanly.
module ms_tick_gen #(
    parameter int unsigned DIV = 50_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST) && !clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tone_transmitter.sv
// Single-band tone transmitter: TONE burst then silent GAP.
// `TONE_BURST_EN adds burst_cnt for back-to-back TONE/GAP pairs.
module tone_transmitter
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TONE_MS = 100,
    parameter int unsigned GAP_MS  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tone_start,
    input  logic [2:0] tone_sel,
`ifdef TONE_BURST_EN
    input  logic [3:0] burst_cnt,
`endif
    output logic       tone_out,
    output logic [4:0] tone_active,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned MS_DIV   = CLK_HZ / 1000;
    localparam int unsigned MS_MAX   = (TONE_MS > GAP_MS) ? TONE_MS : GAP_MS;
    localparam int unsigned MS_W     = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;
    localparam int unsigned HALF_MAX = halfPeriod(CLK_HZ, 3'd1);
    localparam int unsigned HALF_W   = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;

    localparam logic [MS_W-1:0] TONE_LAST = MS_W'(TONE_MS - 1);
    localparam logic [MS_W-1:0] GAP_LAST  = MS_W'(GAP_MS - 1);

    toneState_e        state;
    logic [2:0]        code;
    logic [MS_W-1:0]   msCnt;
    logic [HALF_W-1:0] halfCnt;
    logic [HALF_W-1:0] halfLast;
    logic              msTick;
    logic              startOk;
    logic              toneEnd;
    logic              gapEnd;
    logic              lastPair;

    ms_tick_gen #(
        .DIV (MS_DIV)
    ) u_msTick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .tick (msTick)
    );

    assign halfLast = HALF_W'(halfPeriod(CLK_HZ, code) - 1);
    assign startOk  = tone_start && (state == IDLE) && isValidCode(tone_sel);
    assign toneEnd  = (state == TONE) && msTick && (msCnt == TONE_LAST);
    assign gapEnd   = (state == GAP) && msTick && (msCnt == GAP_LAST);

`ifdef TONE_BURST_EN
    logic [3:0] pairsLeft;

    assign lastPair = (pairsLeft <= 4'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pairsLeft <= '0;
        end else if (startOk) begin
            pairsLeft <= (burst_cnt == 4'd0) ? 4'd1 : burst_cnt;
        end else if (gapEnd && !lastPair) begin
            pairsLeft <= pairsLeft - 4'd1;
        end
    end
`else
    assign lastPair = 1'b1;
`endif

    assign busy        = (state != IDLE);
    assign done        = gapEnd && lastPair;
    assign tone_active = (state == TONE) ? bandOneHot(code) : 5'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            code     <= '0;
            msCnt    <= '0;
            halfCnt  <= '0;
            tone_out <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= tone_start && (state == IDLE) && !isValidCode(tone_sel);
            unique case (state)
                IDLE: begin
                    if (startOk) begin
                        state    <= TONE;
                        code     <= tone_sel;
                        msCnt    <= '0;
                        halfCnt  <= '0;
                        tone_out <= 1'b1;
                    end
                end
                TONE: begin
                    if (toneEnd) begin
                        state    <= GAP;
                        msCnt    <= '0;
                        halfCnt  <= '0;
                        tone_out <= 1'b0;
                    end else begin
                        if (msTick) msCnt <= msCnt + 1'b1;
                        if (halfCnt == halfLast) begin
                            halfCnt  <= '0;
                            tone_out <= ~tone_out;
                        end else begin
                            halfCnt <= halfCnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gapEnd) begin
                        msCnt <= '0;
                        if (lastPair) begin
                            state <= IDLE;
                        end else begin
                            state    <= TONE;
                            halfCnt  <= '0;
                            tone_out <= 1'b1;
                        end
                    end else if (msTick) begin
                        msCnt <= msCnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
